// File: rtl/fpaddsub_sched_pkg.sv
// Shared constants, requester ID and opcode types, and the round-robin pick
// used by the FP add/sub issue scheduler.
package fpaddsub_sched_pkg;

  localparam int FPAS_W           = 32;
  localparam int FPAS_LAT_DEFAULT = 5;

  typedef logic req_id_t;

  typedef enum logic {
    FPAS_OP_ADD = 1'b0,
    FPAS_OP_SUB = 1'b1
  } fpas_op_e;

  // With both requesters eligible, serve the one that was not served last.
  function automatic logic [1:0] rr_pick(input logic [1:0] elig, input req_id_t last_id);
    logic [1:0] gnt;
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_id == 1'b1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/fpaddsub_result_fifo.sv
// Synchronous first-word-fall-through result FIFO with occupancy count, and a
// checker that flags any write into a full FIFO without a same-cycle pop.
module fpaddsub_result_fifo #(
  parameter int  W     = 32,
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_s, empty_s, push_s, pop_s;

  assign empty_s = (count_q == {CW{1'b0}});
  assign full_s  = (count_q == FULL_CNT);
  assign pop_s   = pop_i & ~empty_s;
  // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
  assign push_s  = push_i & (~full_s | pop_s);

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PW{1'b0}} : wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PW{1'b0}} : rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  assign valid_o = ~empty_s;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  fpaddsub_result_fifo_chk u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_i),
    .full_i (full_s),
    .pop_i  (pop_i)
  );

endmodule

module fpaddsub_result_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic push_i,
  input logic full_i,
  input logic pop_i
);

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_i && !pop_i));

endmodule

// File: rtl/fpaddsub_issue_scheduler.sv
// Round-robin issue scheduler sharing one pipelined FP add/sub core between two
// requesters. Define FPAS_SCHED_STATS_EN to add issue/stall statistics counters.
module fpaddsub_issue_scheduler
  import fpaddsub_sched_pkg::*;
#(
  parameter int W     = FPAS_W,
  parameter int LAT   = FPAS_LAT_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [1:0]     ReqValid,
  output logic [1:0]     ReqReady,
  input  logic [2*W-1:0] ReqA,
  input  logic [2*W-1:0] ReqB,
  input  logic [1:0]     ReqOpr,
  output logic           CoreValid,
  output logic [W-1:0]   CoreA,
  output logic [W-1:0]   CoreB,
  output logic           CoreOpr,
  input  logic [W-1:0]   CoreResult,
  output logic [1:0]     ResValid,
  output logic [2*W-1:0] ResData,
  input  logic [1:0]     ResAccept
`ifdef FPAS_SCHED_STATS_EN
  ,
  output logic [31:0]    IssueCnt0,
  output logic [31:0]    IssueCnt1,
  output logic [31:0]    StallCnt
`endif
);

  localparam int            CW     = $clog2(DEPTH + 1);
  localparam int            UW     = CW + 1;
  localparam logic [UW-1:0] CREDIT = UW'(DEPTH);

  logic [1:0]    eligible_s, grant_s, push_s, pop_s;
  logic [UW-1:0] used_s     [2];
  logic [CW-1:0] inflight_q [2];
  logic [CW-1:0] inflight_d [2];
  logic [CW-1:0] fifo_cnt_s [2];
  logic          res_valid_s[2];
  logic [W-1:0]  res_head_s [2];
  req_id_t       win_id_s, rr_last_q, rr_last_d;

  logic          core_valid_q, core_valid_d;
  logic [W-1:0]  core_a_q, core_a_d;
  logic [W-1:0]  core_b_q, core_b_d;
  fpas_op_e      core_opr_q, core_opr_d;
  req_id_t       core_id_q, core_id_d;

  logic [LAT:1]  sh_valid_q;
  logic [LAT:1]  sh_id_q;

  // Credit uses registered counts only, so a pop frees credit one cycle later.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      used_s[k]     = {1'b0, inflight_q[k]} + {1'b0, fifo_cnt_s[k]};
      eligible_s[k] = ReqValid[k] & (used_s[k] < CREDIT);
    end
    grant_s  = rr_pick(eligible_s, rr_last_q) & {2{RST_N}};
    win_id_s = grant_s[1];
  end

  assign ReqReady = grant_s;

  // Operand capture and round-robin pointer update on a grant.
  always_comb begin
    core_valid_d = |grant_s;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    core_opr_d   = core_opr_q;
    core_id_d    = core_id_q;
    rr_last_d    = rr_last_q;
    if (|grant_s) begin
      core_a_d   = win_id_s ? ReqA[2*W-1:W] : ReqA[W-1:0];
      core_b_d   = win_id_s ? ReqB[2*W-1:W] : ReqB[W-1:0];
      core_opr_d = fpas_op_e'(ReqOpr[win_id_s]);
      core_id_d  = win_id_s;
      rr_last_d  = win_id_s;
    end else begin
      core_id_d  = core_id_q;
      rr_last_d  = rr_last_q;
    end
  end

  // Writeback steering and in-flight accounting.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      push_s[k] = sh_valid_q[LAT] & (sh_id_q[LAT] == k[0]);
      pop_s[k]  = ResAccept[k] & res_valid_s[k];
      case ({grant_s[k], push_s[k]})
        2'b10:   inflight_d[k] = inflight_q[k] + CW'(1'b1);
        2'b01:   inflight_d[k] = inflight_q[k] - CW'(1'b1);
        default: inflight_d[k] = inflight_q[k];
      endcase
    end
  end

  // Core issue registers, RR pointer and in-flight counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      core_valid_q  <= 1'b0;
      core_a_q      <= {W{1'b0}};
      core_b_q      <= {W{1'b0}};
      core_opr_q    <= FPAS_OP_ADD;
      core_id_q     <= 1'b0;
      rr_last_q     <= 1'b1;
      inflight_q[0] <= {CW{1'b0}};
      inflight_q[1] <= {CW{1'b0}};
    end else begin
      core_valid_q  <= core_valid_d;
      core_a_q      <= core_a_d;
      core_b_q      <= core_b_d;
      core_opr_q    <= core_opr_d;
      core_id_q     <= core_id_d;
      rr_last_q     <= rr_last_d;
      inflight_q[0] <= inflight_d[0];
      inflight_q[1] <= inflight_d[1];
    end
  end

  // Shadow {valid, id} pipeline follows each issue through the core latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_valid_q <= {LAT{1'b0}};
      sh_id_q    <= {LAT{1'b0}};
    end else begin
      sh_valid_q[1] <= core_valid_q;
      sh_id_q[1]    <= core_id_q;
      for (int i = 2; i <= LAT; i++) begin
        sh_valid_q[i] <= sh_valid_q[i-1];
        sh_id_q[i]    <= sh_id_q[i-1];
      end
    end
  end

  assign CoreValid = core_valid_q;
  assign CoreA     = core_a_q;
  assign CoreB     = core_b_q;
  assign CoreOpr   = core_opr_q;

  for (genvar k = 0; k < 2; k++) begin : g_fifo
    fpaddsub_result_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (CLK),
      .rst_n   (RST_N),
      .push_i  (push_s[k]),
      .data_i  (CoreResult),
      .pop_i   (pop_s[k]),
      .valid_o (res_valid_s[k]),
      .head_o  (res_head_s[k]),
      .count_o (fifo_cnt_s[k])
    );
  end

  assign ResValid = {res_valid_s[1], res_valid_s[0]};
  assign ResData  = {res_head_s[1], res_head_s[0]};

`ifdef FPAS_SCHED_STATS_EN
  logic [31:0] issue_cnt_q [2];
  logic [31:0] stall_cnt_q;

  // Grant and stall statistics, wrapping at 2^32.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      issue_cnt_q[0] <= 32'd0;
      issue_cnt_q[1] <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      issue_cnt_q[0] <= issue_cnt_q[0] + {31'd0, grant_s[0]};
      issue_cnt_q[1] <= issue_cnt_q[1] + {31'd0, grant_s[1]};
      stall_cnt_q    <= stall_cnt_q + {31'd0, (|ReqValid) & ~(|grant_s)};
    end
  end

  assign IssueCnt0 = issue_cnt_q[0];
  assign IssueCnt1 = issue_cnt_q[1];
  assign StallCnt  = stall_cnt_q;
`endif

endmodule
